traffic_phase_ctrl: RTL
=======================

# traffic_phase_ctrl

Phase sequencer for the intersection timer. It drives the loadable 6-bit down-counter stage with the preset value, the load strobe and the count enable. It consumes that counter's terminal-count (RCO) to step through the four lamp phases. It also handles pause, emergency all-red and night flashing modes, and produces the six lamp outputs and a phase code for the display path.

## Interface
Parameters:
- T_NS_G, 30: north–south green duration, in TICKs; legal range 1..64
- T_NS_Y, 3: north–south yellow duration, in TICKs
- T_EW_G, 20: east–west green duration, in TICKs
- T_EW_Y, 3: east–west yellow duration, in TICKs

Ports:
- CLK  in  1  system clock, single clock domain; all state changes on its rising edge
- RSTn  in  1  asynchronous reset, active-low
- TICK  in  1  one-CLK-wide strobe from the 1 Hz prescaler
- RCO  in  1  counter terminal count (counter value == 0)
- PAUSE  in  1  level; freezes timing
- EMERG  in  1  level; forces all-red
- NIGHT  in  1  level; flashing-yellow mode
- LDn  out  1  counter load strobe, active-low, registered
- E  out  1  counter enable, combinational
- PD  out  6  counter preset, combinational from state
- LAMP  out  6  {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G}, registered
- PHASE  out  3  current state code

## Operation
- States: NS_G, NS_Y, EW_G, EW_Y, ALL_RED, NITE.
- Normal cycle: NS_G→NS_Y→EW_G→EW_Y→NS_G.
- Mode priority: EMERG > NIGHT > PAUSE > normal.
- E = TICK & ~PAUSE & ~EMERG & ~NIGHT & (state is one of the four normal phases).
- Advance condition: RCO & E. On that edge, the state moves to the next phase and the counter reloads PD on the same edge.
- PD in a normal phase = (duration of the next phase) − 1. Example: in NS_G, PD = T_NS_Y−1.
- PD in ALL_RED or NITE = T_NS_G−1.
- Phase length: each phase lasts exactly its duration in TICKs, because the counter counts PD..0, which is PD+1 enabled ticks.
- EMERG asserted in any state: next edge enters ALL_RED. LDn stays 1 and E stays 0, so the counter is frozen.
- NIGHT asserted with EMERG=0: next edge enters NITE. The flash register is cleared on entry and toggles on every TICK. NS_Y = EW_Y = flash; all other lamps are 0.
- Exit from ALL_RED or NITE: when the forcing input drops (and no higher-priority input is active), the next edge enters NS_G with LDn=0 for exactly one cycle. The counter therefore loads T_NS_G−1.
- PAUSE: only E is gated. State, lamps and the counter hold. TICKs that arrive while PAUSE is high are lost.
- Lamps by state:
  - NS_G: NS_G and EW_R lit.
  - NS_Y: NS_Y and EW_R lit.
  - EW_G: EW_G and NS_R lit.
  - EW_Y: EW_Y and NS_R lit.
  - ALL_RED: NS_R and EW_R lit.
- PHASE codes: 0..5 in the state order listed above.

## Timing
- Reset values: state = NS_G, LDn = 0, LAMP = 6'b001100 (NS green, EW red), flash = 0, PHASE = 0.
- LDn remains 0 for the first rising edge after RSTn deasserts, so the counter loads T_NS_G−1. LDn = 1 from then on.
- LAMP and PHASE are registered outputs. They update one edge after the state change that drives them.
- Advance takes effect on the edge where RCO & E = 1. There is no extra latency.
- Simultaneous events:
  - EMERG together with RCO & E: EMERG wins and the phase does not advance.
  - PAUSE high on the terminal tick: no advance; the counter stays at 0 until PAUSE drops and the next TICK arrives.
- Reset mid-phase: the asynchronous return to reset values is immediate, regardless of the current counter value.

## Structure
- Shared package holds:
  - the state encoding (3-bit enum of the six states);
  - the LAMP bit-position constants;
  - a function mapping a state to its next-phase duration−1.
- Optional sub-module `lamp_decode`: registered state/flash → LAMP mapping. Everything else stays in a single module.

## Test plan
- Reset release with default parameters:
  - Expected: LDn = 0 for one cycle, PD = 29, LAMP = 001100.
  - The counter model then shows 29.
- Full cycle with the counter model and TICK every 4 CLKs:
  - Expected phase lengths in TICKs: NS_G 30, NS_Y 3, EW_G 20, EW_Y 3.
  - Expected PD sequence: 2, 19, 2, 29.
- PAUSE held for 10 TICKs mid EW_G:
  - Expected: E = 0, counter value and LAMP unchanged.
  - After release, the phase ends exactly 10 TICKs later than it would have without the pause.
- EMERG raised at counter value 5 in NS_G:
  - Expected: ALL_RED next cycle, LAMP = 100100.
  - On release: NS_G, one-cycle LDn = 0 pulse, counter reloads 29.
- NIGHT for 6 TICKs:
  - Expected: both yellows toggle 0→1→0… on each TICK, all other lamps 0.
  - EMERG asserted during NIGHT overrides it to ALL_RED.
- RSTn pulsed low in EW_Y:
  - Expected: immediate NS_G lamps, and LDn = 0 on the first edge after release.

Source files
------------

// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types and helpers for the intersection phase sequencer.
//   phase_e       : 3-bit state encoding, also used as the PHASE display code
//   Lamp*         : bit positions inside the 6-bit LAMP vector
//   next_preset() : counter preset (next phase duration - 1) for a given state
package traffic_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    StNsG    = 3'd0,
    StNsY    = 3'd1,
    StEwG    = 3'd2,
    StEwY    = 3'd3,
    StAllRed = 3'd4,
    StNite   = 3'd5
  } phase_e;

  // LAMP = {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G}
  localparam int unsigned LampNsR = 5;
  localparam int unsigned LampNsY = 4;
  localparam int unsigned LampNsG = 3;
  localparam int unsigned LampEwR = 2;
  localparam int unsigned LampEwY = 1;
  localparam int unsigned LampEwG = 0;

  localparam logic [5:0] LampReset = 6'b001100;

  // Preset loaded when leaving state st: duration of the phase that follows, minus one.
  // Forced modes always resume into NS green.
  function automatic logic [5:0] next_preset(input phase_e st, input int unsigned ns_g,
                                             input int unsigned ns_y, input int unsigned ew_g,
                                             input int unsigned ew_y);
    int unsigned dur;
    case (st)
      StNsG:   dur = ns_y;
      StNsY:   dur = ew_g;
      StEwG:   dur = ew_y;
      default: dur = ns_g;
    endcase
    return 6'(dur - 1);
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_lamp_decode.sv
// Registered state/flash to lamp mapping.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   state_i       : current sequencer state
//   flash_i       : night-mode flash phase
//   lamp_o        : {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G}, one edge behind state_i
module traffic_phase_ctrl_lamp_decode
  import traffic_phase_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  phase_e     state_i,
  input  logic       flash_i,
  output logic [5:0] lamp_o
);

  logic [5:0] lamp_d, lamp_q;

  always_comb begin
    lamp_d = '0;
    case (state_i)
      StNsG: begin
        lamp_d[LampNsG] = 1'b1;
        lamp_d[LampEwR] = 1'b1;
      end
      StNsY: begin
        lamp_d[LampNsY] = 1'b1;
        lamp_d[LampEwR] = 1'b1;
      end
      StEwG: begin
        lamp_d[LampEwG] = 1'b1;
        lamp_d[LampNsR] = 1'b1;
      end
      StEwY: begin
        lamp_d[LampEwY] = 1'b1;
        lamp_d[LampNsR] = 1'b1;
      end
      StAllRed: begin
        lamp_d[LampNsR] = 1'b1;
        lamp_d[LampEwR] = 1'b1;
      end
      StNite: begin
        lamp_d[LampNsY] = flash_i;
        lamp_d[LampEwY] = flash_i;
      end
      default: lamp_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lamp_q <= LampReset;
    end else begin
      lamp_q <= lamp_d;
    end
  end

  assign lamp_o = lamp_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer driving an external loadable 6-bit down-counter.
//   CLK, RSTn          : clock, asynchronous active-low reset
//   TICK               : 1 Hz one-cycle strobe
//   RCO                : counter terminal count (value == 0)
//   PAUSE/EMERG/NIGHT  : mode levels, priority EMERG > NIGHT > PAUSE
//   LDn                : registered active-low counter load
//   E                  : combinational counter enable
//   PD                 : counter preset
//   LAMP               : registered lamp vector {NS_R,NS_Y,NS_G,EW_R,EW_Y,EW_G}
//   PHASE              : registered state code
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int unsigned T_NS_G = 30,
  parameter int unsigned T_NS_Y = 3,
  parameter int unsigned T_EW_G = 20,
  parameter int unsigned T_EW_Y = 3
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TICK,
  input  logic       RCO,
  input  logic       PAUSE,
  input  logic       EMERG,
  input  logic       NIGHT,
  output logic       LDn,
  output logic       E,
  output logic [5:0] PD,
  output logic [5:0] LAMP,
  output logic [2:0] PHASE
);

  phase_e     state_d, state_q;
  logic       ldn_d, ldn_q;
  logic       flash_d, flash_q;
  logic [2:0] phase_q;
  logic       is_normal;
  logic       advance;

  assign is_normal = (state_q == StNsG) || (state_q == StNsY) ||
                     (state_q == StEwG) || (state_q == StEwY);

  assign E = TICK & ~PAUSE & ~EMERG & ~NIGHT & is_normal;

  // While a load is pending the counter value is stale, so RCO must not advance the phase.
  assign advance = RCO & E & ldn_q;

  // A pending load always resumes NS green.
  assign PD = ldn_q ? next_preset(state_q, T_NS_G, T_NS_Y, T_EW_G, T_EW_Y)
                    : 6'(T_NS_G - 1);

  always_comb begin
    state_d = state_q;
    ldn_d   = 1'b1;
    flash_d = flash_q;
    if (EMERG) begin
      state_d = StAllRed;
    end else if (NIGHT) begin
      state_d = StNite;
    end else if (!is_normal) begin
      state_d = StNsG;
      ldn_d   = 1'b0;
    end else if (advance) begin
      case (state_q)
        StNsG:   state_d = StNsY;
        StNsY:   state_d = StEwG;
        StEwG:   state_d = StEwY;
        default: state_d = StNsG;
      endcase
    end

    if ((state_d == StNite) && (state_q != StNite)) begin
      flash_d = 1'b0;
    end else if ((state_q == StNite) && TICK) begin
      flash_d = ~flash_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StNsG;
      ldn_q   <= 1'b0;
      flash_q <= 1'b0;
      phase_q <= 3'd0;
    end else begin
      state_q <= state_d;
      ldn_q   <= ldn_d;
      flash_q <= flash_d;
      phase_q <= state_q;
    end
  end

  traffic_phase_ctrl_lamp_decode u_lamp_decode (
    .clk_i  (CLK),
    .rst_ni (RSTn),
    .state_i(state_q),
    .flash_i(flash_q),
    .lamp_o (LAMP)
  );

  assign LDn   = ldn_q;
  assign PHASE = phase_q;

endmodule
